// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU-side and response signals of the ALU command sequencer
interface alu_cmd_sequencer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          cmd_valid;
   logic          cmd_ready;
   logic [3:0]    cmd_a;
   logic [3:0]    cmd_b;
   logic [1:0]    cmd_op;
   logic [3:0]    alu_a;
   logic [3:0]    alu_b;
   logic [1:0]    alu_opcode;
   logic [4:0]    alu_c;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [4:0]    rsp_c;
   logic [1:0]    rsp_op;
   logic          rsp_zero;
   logic          rsp_neg;
   logic [CW-1:0] count;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_opcode,
      output rsp_valid, rsp_c, rsp_op, rsp_zero, rsp_neg, count
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_c, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_opcode,
      input  rsp_valid, rsp_c, rsp_op, rsp_zero, rsp_neg, count
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - in-order command FIFO plus issue/wait/respond sequencer for the 4-bit ALU
// One command is in flight at a time, so results leave in exactly the order commands arrived.
module alu_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input logic                clock,
   input logic                reset,
   alu_cmd_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [LW-1:0] wait_cnt;
   logic [9:0]    head;
   logic          push;
   logic          issue;
   logic          capture;
   logic          rsp_done;

   logic [3:0]    alu_a_q;
   logic [3:0]    alu_b_q;
   logic [1:0]    alu_op_q;
   logic          rsp_valid_q;
   logic [4:0]    rsp_c_q;
   logic [1:0]    rsp_op_q;
   logic          rsp_zero_q;
   logic          rsp_neg_q;

   // No full bypass: a pop on the same edge never frees room for a push.
   assign bus.cmd_ready = !reset && (cnt != CW'(DEPTH));
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign head          = mem[rd_ptr];

   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      capture  = 1'b0;
      rsp_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (cnt != '0) begin
               issue   = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_done = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, issue})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // The counter is loaded with ALU_LAT at issue and captures when it reaches zero,
   // one edge after the ALU's output has settled.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
      end else if (issue) begin
         wait_cnt <= LW'(ALU_LAT);
         alu_a_q  <= head[9:6];
         alu_b_q  <= head[5:2];
         alu_op_q <= head[1:0];
      end else if (state_q == WAIT && wait_cnt != '0) begin
         wait_cnt <= wait_cnt - LW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_c_q     <= '0;
         rsp_op_q    <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_neg_q   <= 1'b0;
      end else if (capture) begin
         rsp_valid_q <= 1'b1;
         rsp_c_q     <= bus.alu_c;
         rsp_op_q    <= alu_op_q;
         rsp_zero_q  <= (bus.alu_c == 5'd0);
         rsp_neg_q   <= bus.alu_c[4];
      end else if (rsp_done) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_opcode = alu_op_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_c      = rsp_c_q;
   assign bus.rsp_op     = rsp_op_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_neg    = rsp_neg_q;
   assign bus.count      = cnt;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a 1-cycle golden ALU
module tb_alu_cmd_sequencer;
   localparam int DEPTH   = 4;
   localparam int ALU_LAT = 1;
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] op;
   } cmd_t;

   logic clock = 1'b0;
   logic reset;

   alu_cmd_sequencer_if #(.DEPTH(DEPTH)) ifc();

   alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always #5 clock = ~clock;

   // Golden ALU: registered 5-bit result from sign-extended operands.
   always @(posedge clock) begin
      case (ifc.alu_opcode)
         2'b00:   ifc.alu_c <= {ifc.alu_a[3], ifc.alu_a} + {ifc.alu_b[3], ifc.alu_b};
         2'b01:   ifc.alu_c <= {ifc.alu_a[3], ifc.alu_a} - {ifc.alu_b[3], ifc.alu_b};
         2'b10:   ifc.alu_c <= ~{ifc.alu_a[3], ifc.alu_a};
         default: ifc.alu_c <= {4'b0000, |ifc.alu_a};
      endcase
   end

   cmd_t       cmd_q[$];
   logic [8:0] exp_q[$];
   logic [8:0] want_q[$];
   logic [8:0] got_q[$];
   int         fire_cyc[$];
   int         cyc = 0;
   int         n_acc = 0;
   int         full_push_err = 0;
   int         tests = 0;
   int         fails = 0;

   function automatic cmd_t mk(logic [3:0] a, logic [3:0] b, logic [1:0] op);
      cmd_t c;
      c.a  = a;
      c.b  = b;
      c.op = op;
      return c;
   endfunction

   // Reference response {c, op, zero, neg} computed with integer arithmetic.
   function automatic logic [8:0] ref_rsp(cmd_t c);
      int         sa;
      int         sb;
      int         r;
      logic [4:0] v;
      sa = int'($signed(c.a));
      sb = int'($signed(c.b));
      case (c.op)
         2'd0:    r = sa + sb;
         2'd1:    r = sa - sb;
         2'd2:    r = -sa - 1;
         default: r = (sa != 0) ? 1 : 0;
      endcase
      v = r[4:0];
      return {v, c.op, (v == 5'd0), v[4]};
   endfunction

   task automatic drive();
      if (cmd_q.size() > 0) begin
         ifc.cmd_valid = 1'b1;
         ifc.cmd_a     = cmd_q[0].a;
         ifc.cmd_b     = cmd_q[0].b;
         ifc.cmd_op    = cmd_q[0].op;
      end else begin
         ifc.cmd_valid = 1'b0;
      end
   endtask

   // Observe handshakes that will complete at the coming edge, advance one cycle, redrive.
   task automatic tick();
      bit acc;
      bit fire;
      acc  = !reset && ifc.cmd_valid && ifc.cmd_ready && (cmd_q.size() > 0);
      fire = !reset && ifc.rsp_valid && ifc.rsp_ready;
      if (acc && ifc.count >= FULL_CNT) full_push_err++;
      if (fire) begin
         got_q.push_back({ifc.rsp_c, ifc.rsp_op, ifc.rsp_zero, ifc.rsp_neg});
         if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
         else                  want_q.push_back(9'h1FF);
         fire_cyc.push_back(cyc);
      end
      if (acc) begin
         exp_q.push_back(ref_rsp(cmd_q[0]));
         void'(cmd_q.pop_front());
         n_acc++;
      end
      if (reset) exp_q.delete();
      @(posedge clock);
      #1;
      cyc++;
      drive();
   endtask

   task automatic clear_logs();
      got_q.delete();
      want_q.delete();
      fire_cyc.delete();
   endtask

   task automatic wait_rsp(int n, int bound);
      int k;
      k = 0;
      while (got_q.size() < n && k < bound) begin
         tick();
         k++;
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      ifc.cmd_valid = 1'b1;
      ifc.cmd_a     = 4'h5;
      ifc.cmd_b     = 4'h3;
      ifc.cmd_op    = 2'b01;
      ifc.rsp_ready = 1'b0;
      tick();
      tick();
      tests++;
      if (ifc.cmd_ready !== 1'b0) begin
         fails++; $display("FAIL reset_cmd_ready: got %b want 0", ifc.cmd_ready);
      end
      tests++;
      if (ifc.count !== '0 || ifc.rsp_valid !== 1'b0) begin
         fails++; $display("FAIL reset_count_valid: count %0d rsp_valid %b want 0 0", ifc.count, ifc.rsp_valid);
      end
      tests++;
      if ({ifc.alu_a, ifc.alu_b, ifc.alu_opcode} !== 10'd0) begin
         fails++; $display("FAIL reset_alu: got %h want 0", {ifc.alu_a, ifc.alu_b, ifc.alu_opcode});
      end
      tests++;
      if ({ifc.rsp_c, ifc.rsp_op, ifc.rsp_zero, ifc.rsp_neg} !== 9'd0) begin
         fails++; $display("FAIL reset_rsp: got %h want 0", {ifc.rsp_c, ifc.rsp_op, ifc.rsp_zero, ifc.rsp_neg});
      end
      reset         = 1'b0;
      ifc.cmd_valid = 1'b0;
      tick();
      tests++;
      if (ifc.count !== '0 || ifc.cmd_ready !== 1'b1 || ifc.rsp_valid !== 1'b0) begin
         fails++; $display("FAIL reset_release: count %0d cmd_ready %b rsp_valid %b want 0 1 0",
                           ifc.count, ifc.cmd_ready, ifc.rsp_valid);
      end
   endtask

   task automatic test_single_add();
      clear_logs();
      ifc.rsp_ready = 1'b1;
      cmd_q.push_back(mk(4'b0110, 4'b1011, 2'b00));
      drive();
      tick();
      tests++;
      if (ifc.count !== CW'(1) || ifc.rsp_valid !== 1'b0) begin
         fails++; $display("FAIL add_e0: count %0d rsp_valid %b want 1 0", ifc.count, ifc.rsp_valid);
      end
      tick();
      tests++;
      if (ifc.alu_a !== 4'b0110 || ifc.alu_b !== 4'b1011 || ifc.alu_opcode !== 2'b00) begin
         fails++; $display("FAIL add_issue: alu %b %b %b want 0110 1011 00", ifc.alu_a, ifc.alu_b, ifc.alu_opcode);
      end
      tick();
      tests++;
      if (ifc.rsp_valid !== 1'b0) begin
         fails++; $display("FAIL add_e2_valid: got %b want 0", ifc.rsp_valid);
      end
      tick();
      tests++;
      if (ifc.rsp_valid !== 1'b1) begin
         fails++; $display("FAIL add_e3_valid: got %b want 1", ifc.rsp_valid);
      end
      tests++;
      if ({ifc.rsp_c, ifc.rsp_op, ifc.rsp_zero, ifc.rsp_neg} !== {5'b00001, 2'b00, 1'b0, 1'b0}) begin
         fails++; $display("FAIL add_rsp: got %b want 000010000", {ifc.rsp_c, ifc.rsp_op, ifc.rsp_zero, ifc.rsp_neg});
      end
      tick();
      tests++;
      if (ifc.rsp_valid !== 1'b0 || got_q.size() !== 1) begin
         fails++; $display("FAIL add_one_cycle: rsp_valid %b responses %0d want 0 1", ifc.rsp_valid, got_q.size());
      end
   endtask

   task automatic test_flags_back_to_back();
      clear_logs();
      ifc.rsp_ready = 1'b1;
      cmd_q.push_back(mk(4'b0110, 4'b1011, 2'b01));
      cmd_q.push_back(mk(4'b1000, 4'b0111, 2'b01));
      cmd_q.push_back(mk(4'b0011, 4'b1101, 2'b00));
      drive();
      wait_rsp(3, 60);
      tests++;
      if (got_q.size() !== 3) begin
         fails++; $display("FAIL flags_count: got %0d want 3", got_q.size());
      end else begin
         tests++;
         if (got_q[0] !== {5'b01011, 2'b01, 1'b0, 1'b0}) begin
            fails++; $display("FAIL flags_sub_pos: got %b want 010110100", got_q[0]);
         end
         tests++;
         if (got_q[1] !== {5'b10001, 2'b01, 1'b0, 1'b1}) begin
            fails++; $display("FAIL flags_sub_neg: got %b want 100010101", got_q[1]);
         end
         tests++;
         if (got_q[2] !== {5'b00000, 2'b00, 1'b1, 1'b0}) begin
            fails++; $display("FAIL flags_zero: got %b want 000000010", got_q[2]);
         end
         tests++;
         if (fire_cyc[1] - fire_cyc[0] != ALU_LAT + 3 || fire_cyc[2] - fire_cyc[1] != ALU_LAT + 3) begin
            fails++; $display("FAIL back_to_back_period: got %0d %0d want %0d",
                              fire_cyc[1] - fire_cyc[0], fire_cyc[2] - fire_cyc[1], ALU_LAT + 3);
         end
      end
   endtask

   task automatic test_full_fifo();
      int acc0;
      clear_logs();
      ifc.rsp_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 8; i++) cmd_q.push_back(mk(4'(i), 4'(9 - i), 2'(i % 4)));
      drive();
      repeat (8) tick();
      tests++;
      if (n_acc - acc0 != 5) begin
         fails++; $display("FAIL full_accepted: got %0d want 5", n_acc - acc0);
      end
      tests++;
      if (ifc.count !== FULL_CNT || ifc.cmd_ready !== 1'b0 || ifc.rsp_valid !== 1'b1) begin
         fails++; $display("FAIL full_state: count %0d cmd_ready %b rsp_valid %b want 4 0 1",
                           ifc.count, ifc.cmd_ready, ifc.rsp_valid);
      end
      ifc.rsp_ready = 1'b1;
      wait_rsp(8, 200);
      tests++;
      if (got_q.size() !== 8 || cmd_q.size() !== 0) begin
         fails++; $display("FAIL full_drain: responses %0d pending %0d want 8 0", got_q.size(), cmd_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== want_q[i]) begin
            fails++; $display("FAIL full_order[%0d]: got %b want %b", i, got_q[i], want_q[i]);
         end
      end
      tests++;
      if (full_push_err != 0) begin
         fails++; $display("FAIL full_no_push_when_full: got %0d pushes want 0", full_push_err);
      end
   endtask

   task automatic test_backpressure();
      cmd_t       c0;
      logic [8:0] r0;
      int         k;
      clear_logs();
      ifc.rsp_ready = 1'b0;
      c0 = mk(4'b0101, 4'b0010, 2'b01);
      r0 = ref_rsp(c0);
      cmd_q.push_back(c0);
      cmd_q.push_back(mk(4'b1111, 4'b0001, 2'b10));
      cmd_q.push_back(mk(4'b0000, 4'b0100, 2'b11));
      drive();
      k = 0;
      while (ifc.rsp_valid !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      tests++;
      if (ifc.rsp_valid !== 1'b1 || ifc.count !== CW'(2)) begin
         fails++; $display("FAIL bp_enter: rsp_valid %b count %0d want 1 2", ifc.rsp_valid, ifc.count);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if (ifc.rsp_valid !== 1'b1 || {ifc.rsp_c, ifc.rsp_op, ifc.rsp_zero, ifc.rsp_neg} !== r0 ||
             {ifc.alu_a, ifc.alu_b, ifc.alu_opcode} !== {c0.a, c0.b, c0.op} || ifc.count !== CW'(2)) begin
            fails++; $display("FAIL bp_hold[%0d]: valid %b rsp %b alu %b count %0d want 1 %b %b 2", i,
                              ifc.rsp_valid, {ifc.rsp_c, ifc.rsp_op, ifc.rsp_zero, ifc.rsp_neg},
                              {ifc.alu_a, ifc.alu_b, ifc.alu_opcode}, ifc.count, r0, {c0.a, c0.b, c0.op});
         end
      end
      ifc.rsp_ready = 1'b1;
      wait_rsp(3, 100);
      tests++;
      if (got_q.size() !== 3) begin
         fails++; $display("FAIL bp_drain: got %0d want 3", got_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== want_q[i]) begin
            fails++; $display("FAIL bp_order[%0d]: got %b want %b", i, got_q[i], want_q[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      cmd_t c[5];
      clear_logs();
      ifc.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         c[i] = mk(4'(i + 2), 4'(12 - i), 2'(i % 4));
         cmd_q.push_back(c[i]);
      end
      drive();
      repeat (8) tick();
      ifc.rsp_ready = 1'b1;
      wait_rsp(1, 10);
      tick();
      tests++;
      if (ifc.count !== CW'(3) || ifc.alu_a !== c[1].a) begin
         fails++; $display("FAIL mid_issue: count %0d alu_a %b want 3 %b", ifc.count, ifc.alu_a, c[1].a);
      end
      reset = 1'b1;
      tick();
      tests++;
      if (ifc.rsp_valid !== 1'b0 || ifc.count !== '0 || {ifc.alu_a, ifc.alu_b, ifc.alu_opcode} !== 10'd0) begin
         fails++; $display("FAIL mid_reset_state: rsp_valid %b count %0d alu %h want 0 0 0",
                           ifc.rsp_valid, ifc.count, {ifc.alu_a, ifc.alu_b, ifc.alu_opcode});
      end
      reset = 1'b0;
      repeat (20) tick();
      tests++;
      if (got_q.size() !== 1 || got_q[0] !== ref_rsp(c[0])) begin
         fails++; $display("FAIL mid_reset_discard: responses %0d first %b want 1 %b",
                           got_q.size(), got_q[0], ref_rsp(c[0]));
      end
   endtask

   task automatic test_random();
      int pushed;
      int k;
      clear_logs();
      pushed = 0;
      k = 0;
      while ((got_q.size() < 40) && k < 3000) begin
         if (pushed < 40 && $urandom_range(0, 1) == 1) begin
            cmd_q.push_back(mk(4'($urandom), 4'($urandom), 2'($urandom)));
            pushed++;
            drive();
         end
         ifc.rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         k++;
      end
      tests++;
      if (got_q.size() !== 40) begin
         fails++; $display("FAIL random_count: got %0d want 40", got_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
         tests++;
         if (got_q[i] !== want_q[i]) begin
            fails++; $display("FAIL random_rsp[%0d]: got %b want %b", i, got_q[i], want_q[i]);
         end
      end
      tests++;
      if (full_push_err != 0) begin
         fails++; $display("FAIL random_no_push_when_full: got %0d want 0", full_push_err);
      end
   endtask

   initial begin
      reset         = 1'b1;
      ifc.cmd_valid = 1'b0;
      ifc.cmd_a     = '0;
      ifc.cmd_b     = '0;
      ifc.cmd_op    = '0;
      ifc.rsp_ready = 1'b0;
      test_reset();
      test_single_add();
      test_flags_back_to_back();
      test_full_fifo();
      test_backpressure();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
